// File: rtl/dct_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dct_sched_pkg
// Description : Shared constants and types for the dct_idct block scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dct_sched_pkg;

    localparam int BLK    = 64;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;

    // Marker travelling alongside each sample through the core latency
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FEED = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dct_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : dct_pingpong_buf
// Description : Two-bank 64x8 sample store, one write port, one registered
//               read port that outputs zero when not enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_pingpong_buf
    import dct_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_wr_bank,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic              i_rd_bank,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2*BLK];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    // The read register doubles as the core's xin driver, so it idles at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/dct_block_sched.sv
`default_nettype none
// ============================================================================
// Module      : dct_block_sched
// Description : Buffers whole 8x8 blocks in a ping-pong store, feeds them
//               gap-free to the dct_idct core and frames its output.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_block_sched
    import dct_sched_pkg::*;
#(
    parameter int LATENCY = 128
)(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] xin,
    input  logic [DATA_W-1:0] idct_2d,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(BLK - 1);
    localparam logic [ADDR_W-1:0] c_one  = ADDR_W'(1);

    logic              r_run;
    logic              r_wb;
    logic [ADDR_W-1:0] r_wcnt;
    logic [1:0]        r_full;
    logic [1:0]        w_full_nxt;
    logic              w_hs;
    logic              w_wr_done;
    logic              w_rd_done;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rb;
    logic              w_rb_nxt;
    logic [ADDR_W-1:0] r_rcnt;
    logic [ADDR_W-1:0] w_rcnt_nxt;
    logic              w_rd_en;
    logic              w_next_ready;
    tag_t              w_tag;

    tag_t              r_tag_x;
    tag_t              r_dly [LATENCY];
    logic              w_dly_busy;

    logic [DATA_W-1:0] r_out_data;
    tag_t              r_out_tag;

    // ------------------------------------------------------------------ write
    assign in_ready  = r_run & ~r_full[r_wb];
    assign w_hs      = in_valid & in_ready;
    assign w_wr_done = w_hs & (r_wcnt == c_last);
    assign w_rd_done = (r_state == FEED) & (r_rcnt == c_last);

    // Reader and writer never touch the same bank's flag in one cycle
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_done) begin
            w_full_nxt[r_rb] = 1'b0;
        end
        if (w_wr_done) begin
            w_full_nxt[r_wb] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_run  <= 1'b0;
            r_wb   <= 1'b0;
            r_wcnt <= '0;
            r_full <= '0;
        end else begin
            r_run  <= 1'b1;
            r_full <= w_full_nxt;
            if (w_hs) begin
                r_wcnt <= r_wcnt + c_one;
                if (w_wr_done) begin
                    r_wb <= ~r_wb;
                end
            end
        end
    end

    // ------------------------------------------------------------------- read
    // A block finishing its write this very cycle still counts as ready, so
    // back-to-back blocks chain on xin without a bubble.
    assign w_next_ready = r_full[~r_rb] | (w_wr_done & (r_wb == ~r_rb));

    always_comb begin
        w_state_nxt = r_state;
        w_rb_nxt    = r_rb;
        w_rcnt_nxt  = r_rcnt;
        w_rd_en     = 1'b0;
        w_tag       = '0;
        case (r_state)
            IDLE: begin
                if (r_full[r_rb]) begin
                    w_state_nxt = FEED;
                    w_rcnt_nxt  = '0;
                end
            end
            FEED: begin
                w_rd_en     = 1'b1;
                w_tag.valid = 1'b1;
                w_tag.first = (r_rcnt == '0);
                w_tag.last  = (r_rcnt == c_last);
                w_rcnt_nxt  = r_rcnt + c_one;
                if (r_rcnt == c_last) begin
                    w_rb_nxt = ~r_rb;
                    if (!w_next_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_rb    <= 1'b0;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rb    <= w_rb_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    dct_pingpong_buf u_buf (
        .clk       (CLK),
        .rst_n     (RST),
        .i_we      (w_hs),
        .i_wr_bank (r_wb),
        .i_wr_addr (r_wcnt),
        .i_wr_data (in_data),
        .i_rd_en   (w_rd_en),
        .i_rd_bank (r_rb),
        .i_rd_addr (r_rcnt),
        .o_rd_data (xin)
    );

    // ---------------------------------------------------------------- markers
    // r_tag_x lines up with xin; LATENCY further stages line up with idct_2d.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_tag_x <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_tag_x  <= w_tag;
            r_dly[0] <= r_tag_x;
            for (int i = 1; i < LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_out_data <= '0;
            r_out_tag  <= '0;
        end else begin
            r_out_data <= idct_2d;
            r_out_tag  <= r_dly[LATENCY-1];
        end
    end

    always_comb begin
        w_dly_busy = r_tag_x.valid;
        for (int i = 0; i < LATENCY; i++) begin
            w_dly_busy = w_dly_busy | r_dly[i].valid;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_tag.valid;
    assign out_first = r_out_tag.first;
    assign out_last  = r_out_tag.last;
    assign busy      = r_full[0] | r_full[1] | (r_state == FEED) | w_dly_busy;

endmodule
`default_nettype wire

// File: tb/tb_dct_block_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_block_sched
// Description : Directed self-checking bench; the core is modelled as a pure
//               LATENCY-cycle delay from xin to idct_2d.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_block_sched;

    localparam int L = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] xin;
    logic [7:0] idct_2d;
    logic [7:0] out_data;
    logic       out_valid, out_first, out_last, busy;

    always #5 CLK = ~CLK;

    dct_block_sched #(.LATENCY(L)) dut (
        .CLK(CLK), .RST(RST), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .xin(xin), .idct_2d(idct_2d), .out_data(out_data),
        .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
        .busy(busy)
    );

    // Core model: sample on xin reappears on idct_2d L cycles later
    logic [7:0] pipe [L];
    always @(posedge CLK) begin
        pipe[0] <= xin;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign idct_2d = pipe[L-1];

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    logic [7:0] vec  [64];
    logic [7:0] vec2 [64];
    logic [7:0] exp_q [$];
    int         first_q [$];
    int         last_q [$];
    int         runs_q [$];
    logic [7:0] xh [1024];
    int cyc = 0, run = 0, out_cnt = 0, data_err = 0;
    int hs_cyc = 0, stalls = 0;

    always @(posedge CLK) cyc++;

    // Output scoreboard: in-order data, and the xin sample L+1 cycles earlier
    always @(negedge CLK) begin
        logic [7:0] e;
        if (!RST) begin
            exp_q.delete();
            run = 0;
        end else begin
            xh[cyc[9:0]] = xin;
            if (out_valid) begin
                run++;
                out_cnt++;
                if (exp_q.size() == 0) data_err++;
                else begin
                    e = exp_q.pop_front();
                    if (out_data !== e || xh[10'(cyc - L - 1)] !== e) data_err++;
                end
            end else if (run != 0) begin
                runs_q.push_back(run);
                run = 0;
            end
            if (out_first) first_q.push_back(cyc);
            if (out_last)  last_q.push_back(cyc);
        end
    end

    task automatic push(input logic [7:0] d);
        int  tries = 0;
        bit  done  = 0;
        while (!done && tries < 200) begin
            in_data  = d;
            in_valid = 1'b1;
            done     = in_ready;
            if (!done) stalls++;
            @(negedge CLK);
            if (done) begin
                exp_q.push_back(d);
                hs_cyc = cyc;
            end
            tries++;
        end
        if (!done) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_busy", busy, 0);
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int h, fb, lb, oc, de, bad;
        vec[0] = 8'h28; vec[1] = 8'h21; vec[2] = 8'h21; vec[3] = 8'h16;
        vec[4] = 8'h1A; vec[5] = 8'h28; vec[6] = 8'h24; vec[7] = 8'h1A;
        for (int i = 8; i < 62; i++) vec[i] = 8'((i * 37 + 5) % 255 + 1);
        vec[62] = 8'h08; vec[63] = 8'h00;
        for (int i = 0; i < 64; i++) vec2[i] = ~vec[i];

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_xin", xin, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        RST = 1'b1;

        // Idle after release
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (xin !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        chk("idle_500", bad, 0);

        // Single block
        fb = first_q.size(); lb = last_q.size(); oc = out_cnt; de = data_err; stalls = 0;
        for (int i = 0; i < 64; i++) push(vec[i]);
        in_valid = 1'b0;
        h = hs_cyc;
        chk("t1_no_stall", stalls, 0);
        @(negedge CLK);
        chk("t1_xin_gap", xin, 8'h00);
        @(negedge CLK);
        chk("t1_xin_first", xin, 8'h28);
        repeat (62) @(negedge CLK);
        chk("t1_xin_62", xin, 8'h08);
        @(negedge CLK);
        chk("t1_xin_last", xin, 8'h00);
        drain();
        chk("t1_first_cnt", first_q.size() - fb, 1);
        chk("t1_first_cyc", first_q[fb], h + 2 + L + 1);
        chk("t1_last_gap", last_q[lb] - first_q[fb], 63);
        chk("t1_out_cnt", out_cnt - oc, 64);
        chk("t1_data", data_err - de, 0);

        // Four back-to-back blocks
        fb = first_q.size(); oc = out_cnt; de = data_err;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 64; i++) push(vec[i]);
        in_valid = 1'b0;
        drain();
        chk("t2_out_cnt", out_cnt - oc, 256);
        chk("t2_run", runs_q[runs_q.size() - 1], 256);
        chk("t2_first_cnt", first_q.size() - fb, 4);
        for (int i = 1; i < 4; i++)
            chk("t2_first_space", first_q[fb + i] - first_q[fb + i - 1], 64);
        chk("t2_data", data_err - de, 0);

        // Both banks full
        oc = out_cnt; de = data_err;
        for (int i = 0; i < 128; i++) push(vec[i % 64]);
        in_valid = 1'b0;
        chk("t3_rdy_low", in_ready, 0);
        chk("t3_xin62", xin, 8'h08);
        @(negedge CLK);
        chk("t3_rdy_back", in_ready, 1);
        chk("t3_xin63", xin, 8'h00);
        @(negedge CLK);
        chk("t3_xin_next", xin, 8'h28);
        drain();
        chk("t3_out_cnt", out_cnt - oc, 128);
        chk("t3_data", data_err - de, 0);

        // Gappy input
        fb = first_q.size(); oc = out_cnt; de = data_err; bad = 0;
        for (int i = 0; i < 64; i++) begin
            push(vec2[i]);
            in_valid = 1'b0;
            h = hs_cyc;
            if (xin !== 8'h00) bad++;
            if (i < 63) begin
                @(negedge CLK);
                if (xin !== 8'h00) bad++;
            end
        end
        drain();
        chk("t4_xin_early", bad, 0);
        chk("t4_first_cyc", first_q[fb], h + 2 + L + 1);
        chk("t4_out_cnt", out_cnt - oc, 64);
        chk("t4_data", data_err - de, 0);

        // Reset in the middle of a FEED
        for (int i = 0; i < 64; i++) push(vec2[i]);
        in_valid = 1'b0;
        h = hs_cyc;
        while (cyc < h + 32) @(negedge CLK);
        chk("t5_xin30", xin, vec2[30]);
        RST = 1'b0;
        #1;
        chk("t5_xin", xin, 8'h00);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_rdy_release", in_ready, 1);
        fb = first_q.size(); oc = out_cnt; de = data_err;
        for (int i = 0; i < 64; i++) push(vec[i]);
        in_valid = 1'b0;
        h = hs_cyc;
        drain();
        chk("t5_first_cyc", first_q[fb], h + 2 + L + 1);
        chk("t5_out_cnt", out_cnt - oc, 64);
        chk("t5_data", data_err - de, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
